// File: rtl/deser_8out_pkg.sv
// Shared constants and types for the deser_8out serial-to-parallel expander.
// The bit counter runs 0..7 while collecting a frame; 8 marks a held (pending) frame.
package deser_8out_pkg;

  localparam int FRAME_W = 8;
  localparam int CNT_W   = 4;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [FRAME_W-1:0] frame_t;

  localparam cnt_t CNT_LAST    = cnt_t'(FRAME_W - 1);
  localparam cnt_t CNT_PENDING = cnt_t'(FRAME_W);

  // Bit 7 (last received) lands in the MSB, so frame bit i drives output oi.
  function automatic frame_t pack_frame(input logic last_bit,
                                        input logic [FRAME_W-2:0] low_bits);
    return {last_bit, low_bits};
  endfunction

endpackage

// File: rtl/hold_slot_8.sv
// Eight-bit output register with valid/ready handshake: loads a whole frame,
// holds it under backpressure, and keeps the data after draining.
module hold_slot_8
  import deser_8out_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  frame_t load_data,
  input  logic   out_ready,
  output frame_t data,
  output logic   out_valid,
  output logic   can_load
);

  logic   valid_q, valid_d;
  frame_t data_q, data_d;

  // A new frame may enter when the slot is empty or being drained this cycle.
  assign can_load  = !valid_q || out_ready;
  assign data      = data_q;
  assign out_valid = valid_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load && can_load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/deser_8out.sv
// Serial-to-parallel expander: collects 8 handshaked bits into a frame and
// presents them on o0..o7 with valid/ready flow control and in_start resync.
module deser_8out
  import deser_8out_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic in_valid,
  input  logic in_start,
  output logic in_ready,
  output logic o0,
  output logic o1,
  output logic o2,
  output logic o3,
  output logic o4,
  output logic o5,
  output logic o6,
  output logic o7,
  output logic out_valid,
  input  logic out_ready,
  output logic frame_err
);

  cnt_t                 cnt_q, cnt_d;
  logic [FRAME_W-2:0]   sr_q, sr_d;
  logic                 last_q, last_d;
  logic                 frame_err_q, frame_err_d;

  logic   xfer;
  logic   slot_load;
  frame_t slot_data;
  frame_t slot_out;
  logic   slot_can_load;

  assign in_ready  = !rst && (cnt_q != CNT_PENDING);
  assign xfer      = in_valid && in_ready;
  assign frame_err = frame_err_q;

  always_comb begin
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    last_d      = last_q;
    frame_err_d = 1'b0;
    slot_load   = 1'b0;
    slot_data   = pack_frame(in_bit, sr_q);

    if (cnt_q == CNT_PENDING) begin
      slot_data = pack_frame(last_q, sr_q);
      if (slot_can_load) begin
        slot_load = 1'b1;
        cnt_d     = '0;
      end
    end else if (xfer) begin
      if (in_start) begin
        // Resync: anything collected so far is dropped and flagged.
        sr_d        = '0;
        sr_d[0]     = in_bit;
        cnt_d       = cnt_t'(1);
        frame_err_d = (cnt_q != '0);
      end else if (cnt_q == CNT_LAST) begin
        if (slot_can_load) begin
          slot_load = 1'b1;
          cnt_d     = '0;
        end else begin
          last_d = in_bit;
          cnt_d  = CNT_PENDING;
        end
      end else begin
        for (int i = 0; i < FRAME_W - 1; i++) begin
          if (cnt_q == cnt_t'(i)) begin
            sr_d[i] = in_bit;
          end
        end
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      sr_q        <= '0;
      last_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      last_q      <= last_d;
      frame_err_q <= frame_err_d;
    end
  end

  hold_slot_8 u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (slot_load),
    .load_data (slot_data),
    .out_ready (out_ready),
    .data      (slot_out),
    .out_valid (out_valid),
    .can_load  (slot_can_load)
  );

  assign o0 = slot_out[0];
  assign o1 = slot_out[1];
  assign o2 = slot_out[2];
  assign o3 = slot_out[3];
  assign o4 = slot_out[4];
  assign o5 = slot_out[5];
  assign o6 = slot_out[6];
  assign o7 = slot_out[7];

endmodule

// File: tb/tb_deser_8out.sv
// Self-checking bench for deser_8out: frames are queued as expected results
// when sent and compared whenever the DUT hands a frame to the consumer.
module tb_deser_8out;

  logic clk;
  logic rst;
  logic in_bit;
  logic in_valid;
  logic in_start;
  logic in_ready;
  logic o0, o1, o2, o3, o4, o5, o6, o7;
  logic out_valid;
  logic out_ready;
  logic frame_err;

  logic [7:0] o_bus;
  logic [7:0] exp_q[$];

  int tests_run   = 0;
  int tests_failed = 0;
  int err_count   = 0;
  int mon_cyc     = 0;
  int last_hs     = 0;
  int last_gap    = 0;
  int stall_total = 0;

  deser_8out dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .in_ready  (in_ready),
    .o0        (o0),
    .o1        (o1),
    .o2        (o2),
    .o3        (o3),
    .o4        (o4),
    .o5        (o5),
    .o6        (o6),
    .o7        (o7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  assign o_bus = {o7, o6, o5, o4, o3, o2, o1, o0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Consumer side: every accepted frame is compared against the oldest queued one.
  always @(negedge clk) begin
    mon_cyc++;
    if (frame_err === 1'b1) err_count++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      last_gap = mon_cyc - last_hs;
      last_hs  = mon_cyc;
      checkOutput("scoreboard_has_entry", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        checkOutput("frame", o_bus, exp_q.pop_front());
      end
    end
  end

  task automatic syncTb();
    @(posedge clk);
    #1;
  endtask

  // Offers one bit starting just after a rising edge; returns once it is accepted.
  task automatic applyStimulus(input logic b, input logic s, output int stalls);
    in_valid = 1'b1;
    in_bit   = b;
    in_start = s;
    stalls   = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (in_ready !== 1'b1) checkOutput("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] f, input logic first_start);
    int st;
    exp_q.push_back(f);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(f[i], (i == 0) && first_start, st);
      stall_total += st;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] f;
    int st;

    rst       = 1'b1;
    in_bit    = 1'b0;
    in_valid  = 1'b0;
    in_start  = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_o", o_bus, 8'h00);
    checkOutput("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    syncTb();
    checkOutput("post_rst_in_ready", in_ready, 1);

    // Basic frame: bits 1,0,1,1,0,0,1,0 -> 0x4D
    sendFrame(8'h4D, 1'b1);
    @(negedge clk);
    checkOutput("basic_valid_rise", out_valid, 1);
    @(negedge clk);
    checkOutput("basic_valid_fall", out_valid, 0);

    // Back-to-back frames without bubbles
    syncTb();
    stall_total = 0;
    sendFrame(8'hA5, 1'b1);
    sendFrame(8'h3C, 1'b1);
    @(negedge clk);
    syncTb();
    checkOutput("b2b_stalls", stall_total, 0);
    checkOutput("b2b_gap", last_gap, 8);

    // Backpressure: second frame goes pending while 0xFF is held
    out_ready   = 1'b0;
    stall_total = 0;
    sendFrame(8'hFF, 1'b1);
    sendFrame(8'h01, 1'b1);
    @(negedge clk);
    checkOutput("bp_in_ready_low", in_ready, 0);
    checkOutput("bp_valid_held", out_valid, 1);
    checkOutput("bp_o_held", o_bus, 8'hFF);
    syncTb();
    syncTb();
    @(negedge clk);
    checkOutput("bp_still_stalled", in_ready, 0);
    checkOutput("bp_o_still_held", o_bus, 8'hFF);
    syncTb();
    out_ready = 1'b1;
    syncTb();
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_next_valid", out_valid, 1);
    checkOutput("bp_next_o", o_bus, 8'h01);
    checkOutput("bp_in_ready_back", in_ready, 1);
    syncTb();
    out_ready = 1'b1;
    syncTb();
    syncTb();

    // Resync: three stray bits, then in_start with 0x81
    err_count = 0;
    applyStimulus(1'b1, 1'b1, st);
    applyStimulus(1'b0, 1'b0, st);
    applyStimulus(1'b1, 1'b0, st);
    f = 8'h81;
    exp_q.push_back(f);
    applyStimulus(f[0], 1'b1, st);
    @(negedge clk);
    checkOutput("resync_frame_err", frame_err, 1);
    syncTb();
    for (int i = 1; i < 8; i++) begin
      applyStimulus(f[i], 1'b0, st);
    end
    repeat (3) syncTb();
    checkOutput("resync_err_count", err_count, 1);

    // Reset mid-frame
    err_count = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'(i & 1), (i == 0), st);
    end
    rst = 1'b1;
    syncTb();
    @(negedge clk);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_o", o_bus, 8'h00);
    checkOutput("midrst_frame_err", frame_err, 0);
    rst = 1'b0;
    syncTb();
    checkOutput("midrst_in_ready_back", in_ready, 1);
    sendFrame(8'h5A, 1'b1);
    repeat (3) syncTb();
    checkOutput("midrst_err_count", err_count, 0);

    repeat (4) syncTb();
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
